// File: rtl/asset_reader_if.sv
// Pixel-stream and ROM-read bundle for asset_reader.
//   master (reader side): drives mem_ce, mem_addr, out_valid, out_pixel, out_x, out_y,
//                         out_last; samples mem_data, out_ready.
//   slave  (ROM + consumer side): the mirror image.
// WIDTH/HEIGHT must match the asset_reader instance that uses the bundle.
interface asset_reader_if #(
  parameter int unsigned WIDTH  = 34,
  parameter int unsigned HEIGHT = 24
);
  localparam int unsigned SIZE       = WIDTH * HEIGHT;
  localparam int unsigned ADDR_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned XW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic                  mem_ce;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_pixel;
  logic [XW-1:0]         out_x;
  logic [YW-1:0]         out_y;
  logic                  out_last;

  modport master (
    output mem_ce, mem_addr, out_valid, out_pixel, out_x, out_y, out_last,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_ce, mem_addr, out_valid, out_pixel, out_x, out_y, out_last,
    output mem_data, out_ready
  );
endinterface

// File: rtl/asset_reader.sv
// Read-side master for the 1-bit asset ROM. Walks one WIDTH x HEIGHT asset in raster
// order, drives the ROM ce/addr and presents the registered ROM bit as a pixel stream
// with valid/ready backpressure, coordinates and a last flag.
// Ports:
//   clk    - clock, posedge
//   rst    - synchronous reset, active low
//   hflip  - (only with ASSET_READER_HFLIP_EN) mirror horizontally, sampled on start
//   start  - 1-cycle stream request, honoured only when idle
//   busy   - stream in progress (until the final pixel is accepted)
//   done   - 1-cycle pulse after the final pixel handshake
//   bus    - asset_reader_if.master: ROM read port and output pixel stream
// Optional feature macro: ASSET_READER_HFLIP_EN (adds the hflip input).
module asset_reader #(
  parameter int unsigned WIDTH  = 34,
  parameter int unsigned HEIGHT = 24
) (
  input  logic clk,
  input  logic rst,
`ifdef ASSET_READER_HFLIP_EN
  input  logic hflip,
`endif
  input  logic start,
  output logic busy,
  output logic done,
  asset_reader_if.master bus
);
  localparam int unsigned SIZE       = WIDTH * HEIGHT;
  localparam int unsigned ADDR_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned XW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [XW-1:0]         ColMax  = XW'(WIDTH - 1);
  localparam logic [YW-1:0]         RowMax  = YW'(HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] RowStep = ADDR_WIDTH'(WIDTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [XW-1:0]         col_q, col_d;
  logic [YW-1:0]         row_q, row_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  done_q, done_d;
  logic                  valid_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic                  last_q;

  logic          issue;
  logic          handshake;
  logic          col_end;
  logic          row_end;
  logic [XW-1:0] col_eff;

  assign col_end   = (col_q == ColMax);
  assign row_end   = (row_q == RowMax);
  assign handshake = valid_q && bus.out_ready;
  // The ROM holds its output while ce=0, so a read may only be issued when the
  // output slot is empty or being emptied this cycle.
  assign issue     = (state_q == StRun) && (!valid_q || bus.out_ready);

`ifdef ASSET_READER_HFLIP_EN
  logic flip_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      flip_q <= 1'b0;
    end else if ((state_q == StIdle) && start) begin
      flip_q <= hflip;
    end
  end

  assign col_eff = flip_q ? (ColMax - col_q) : col_q;
`else
  assign col_eff = col_q;
`endif

  // Running row base avoids a row*WIDTH multiplier.
  assign bus.mem_ce   = issue;
  assign bus.mem_addr = (state_q == StRun) ? (base_q + ADDR_WIDTH'(col_eff)) : '0;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
        end
      end
      StRun: begin
        if (issue) begin
          if (col_end) begin
            col_d = '0;
            if (row_end) begin
              // Final read issued; park counters at zero instead of wrapping past HEIGHT.
              row_d   = '0;
              base_d  = '0;
              state_d = StDrain;
            end else begin
              row_d  = row_q + 1'b1;
              base_d = base_q + RowStep;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // done pulses while still in DRAIN so a coincident start is ignored.
        if (done_q) begin
          state_d = StIdle;
        end else if (handshake) begin
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      done_q  <= done_d;
      if (issue) begin
        // Tags captured with the read so they line up with mem_data next cycle.
        valid_q <= 1'b1;
        x_q     <= col_q;
        y_q     <= row_q;
        last_q  <= col_end && row_end;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign busy          = (state_q == StRun) || ((state_q == StDrain) && !done_q);
  assign done          = done_q;
  assign bus.out_valid = valid_q;
  assign bus.out_pixel = bus.mem_data;
  assign bus.out_x     = x_q;
  assign bus.out_y     = y_q;
  assign bus.out_last  = last_q;
endmodule

// File: tb/tb_asset_reader.sv
// Bench for asset_reader: a 4x2 instance checked by a queue scoreboard against a
// raster-order reference model, plus a 1x3 instance checked in-line.
module tb_asset_reader;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned S  = W * H;
  localparam int unsigned W1 = 1;
  localparam int unsigned H1 = 3;

  typedef struct {
    logic pix;
    int   x;
    int   y;
    logic last;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic start1 = 1'b0;
  logic busy1, done1;
  logic rdy = 1'b1;
  int   rdy_mode = 0;

  logic [S-1:0]  rom = '0;
  logic          rom_q = 1'b0;
  logic [H1-1:0] rom1 = '0;
  logic          rom1_q = 1'b0;

  pix_t pix_q[$];
  int   addr_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  asset_reader_if #(.WIDTH(W), .HEIGHT(H)) bus ();
  asset_reader_if #(.WIDTH(W1), .HEIGHT(H1)) bus1 ();

`ifdef ASSET_READER_HFLIP_EN
  logic hflip = 1'b0;
  logic hflip1 = 1'b0;
`endif

  asset_reader #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef ASSET_READER_HFLIP_EN
    .hflip (hflip),
`endif
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  asset_reader #(.WIDTH(W1), .HEIGHT(H1)) dut1 (
    .clk   (clk),
    .rst   (rst),
`ifdef ASSET_READER_HFLIP_EN
    .hflip (hflip1),
`endif
    .start (start1),
    .busy  (busy1),
    .done  (done1),
    .bus   (bus1)
  );

  // Behavioural ROMs: registered output, held while ce=0.
  always @(posedge clk) if (bus.mem_ce) rom_q <= rom[bus.mem_addr];
  always @(posedge clk) if (bus1.mem_ce) rom1_q <= rom1[bus1.mem_addr];
  assign bus.mem_data   = rom_q;
  assign bus.out_ready  = rdy;
  assign bus1.mem_data  = rom1_q;
  assign bus1.out_ready = 1'b1;

  initial forever begin
    @(posedge clk);
    #1;
    rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: pixel i of the raster walk is (i%W, i/W); its ROM word is
  // row*W + column, the column mirrored when flipping.
  task automatic push_stream(input bit flip);
    for (int i = 0; i < int'(S); i++) begin
      pix_t e;
      int x;
      int y;
      int a;
      x = i % int'(W);
      y = i / int'(W);
      a = y * int'(W) + (flip ? (int'(W) - 1 - x) : x);
      e.pix  = rom[a];
      e.x    = x;
      e.y    = y;
      e.last = (i == int'(S) - 1);
      pix_q.push_back(e);
      addr_q.push_back(a);
    end
  endtask

  // Monitor: every issued address and every presented pixel is checked against the
  // front of the scoreboard; a pixel is retired only on handshake.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.mem_ce) begin
          if (addr_q.size() == 0) chk("addr_unexpected", 1, 0);
          else chk("mem_addr", int'(bus.mem_addr), addr_q.pop_front());
        end
        if (bus.out_valid) begin
          if (pix_q.size() == 0) begin
            chk("pixel_unexpected", 1, 0);
          end else begin
            e = pix_q[0];
            chk("out_pixel", int'(bus.out_pixel), int'(e.pix));
            chk("out_x", int'(bus.out_x), e.x);
            chk("out_y", int'(bus.out_y), e.y);
            chk("out_last", int'(bus.out_last), int'(e.last));
            if (bus.out_ready) void'(pix_q.pop_front());
            else chk("stall_no_issue", int'(bus.mem_ce), 0);
          end
        end
      end
    end
  end

  task automatic run_stream(input bit flip, input bit extra_start, input bit chk_busy);
    int busy_cnt = 0;
    int first_valid = -1;
    bit fin = 1'b0;
    @(posedge clk);
    #1;
`ifdef ASSET_READER_HFLIP_EN
    hflip = flip;
`endif
    push_stream(flip);
    start = 1'b1;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (extra_start && k == 4) start = 1'b1;
      if (extra_start && k == 5) start = 1'b0;
      if (busy) busy_cnt++;
      if (bus.out_valid && first_valid < 0) first_valid = k;
      if (done) begin
        fin = 1'b1;
        if (extra_start) start = 1'b1;
      end
    end
    if (!fin) chk("stream_timeout", 0, 1);
    chk("first_valid_latency", first_valid, 2);
    if (chk_busy) chk("busy_cycles", busy_cnt, int'(S) + 1);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      chk("idle_busy", int'(busy), 0);
      chk("single_done", int'(done), 0);
    end
    chk("pixels_drained", pix_q.size(), 0);
    chk("addrs_drained", addr_q.size(), 0);
  endtask

  task automatic reset_mid();
    int hs = 0;
    bit hit = 1'b0;
    @(posedge clk);
    #1;
    push_stream(1'b0);
    start = 1'b1;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (bus.out_valid && hs == 3) begin
        rst = 1'b0;
        hit = 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        hs++;
      end
    end
    if (!hit) chk("reset_point_timeout", 0, 1);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mem_ce", int'(bus.mem_ce), 0);
    chk("rst_done", int'(done), 0);
    pix_q.delete();
    addr_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_no_done_after", int'(done), 0);
    chk("rst_idle_addr", int'(bus.mem_addr), 0);
  endtask

  task automatic run_small();
    int a_exp = 0;
    int hs = 0;
    bit fin = 1'b0;
    rom1 = H1'($urandom);
    @(posedge clk);
    #1;
    start1 = 1'b1;
    for (int k = 0; k < 50 && !fin; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      if (bus1.mem_ce) begin
        chk("w1_addr", int'(bus1.mem_addr), a_exp);
        a_exp++;
      end
      if (bus1.out_valid) begin
        chk("w1_pixel", int'(bus1.out_pixel), int'(rom1[hs]));
        chk("w1_x", int'(bus1.out_x), 0);
        chk("w1_y", int'(bus1.out_y), hs);
        chk("w1_last", int'(bus1.out_last), int'(hs == int'(H1) - 1));
        hs++;
      end
      if (done1) begin
        chk("w1_done_after_last", hs, int'(H1));
        fin = 1'b1;
      end
    end
    if (!fin) chk("w1_timeout", 0, 1);
    chk("w1_issue_count", a_exp, int'(H1));
  endtask

  initial begin
    rom = 8'b1011_0010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_mem_ce", int'(bus.mem_ce), 0);
    chk("reset_mem_addr", int'(bus.mem_addr), 0);
    chk("reset_out_x", int'(bus.out_x), 0);
    chk("reset_out_y", int'(bus.out_y), 0);
    chk("reset_out_last", int'(bus.out_last), 0);
    rst = 1'b1;

    run_stream(1'b0, 1'b0, 1'b1);
    rdy_mode = 1;
    run_stream(1'b0, 1'b0, 1'b0);
    rdy_mode = 0;
    run_stream(1'b0, 1'b1, 1'b1);
    reset_mid();
    run_stream(1'b0, 1'b0, 1'b1);
`ifdef ASSET_READER_HFLIP_EN
    run_stream(1'b1, 1'b0, 1'b1);
    rdy_mode = 1;
    run_stream(1'b1, 1'b0, 1'b0);
    rdy_mode = 0;
`endif
    rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      rom = S'($urandom);
      run_stream(1'b0, 1'b0, 1'b0);
    end
    rdy_mode = 0;
    run_small();
    run_small();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/asset_reader.md
Name: asset_reader

Overview:
- Read-side master for the 1-bit asset ROM (`asset_mem`).
- Walks one WIDTH x HEIGHT asset in raster order and drives the ROM's `ce`/`addr`. It takes the ROM's registered 1-cycle-latency output bit and presents it as a pixel stream with valid/ready backpressure, plus pixel coordinates and a last flag.
- Sits between `asset_mem` and the frame compositor/renderer that draws sprites (bird, pipes).

Parameters:
- WIDTH, 34, asset width in pixels (>=1).
- HEIGHT, 24, asset height in pixels (>=1).
- SIZE = WIDTH*HEIGHT is a localparam. ADDR_WIDTH = $clog2(SIZE), matching the ROM address width. XW = $clog2(WIDTH) and YW = $clog2(HEIGHT), each with a minimum of 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (rst=0 resets).
- start  in  1  1-cycle request to stream the asset; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until the final pixel is accepted.
- done  out  1  1-cycle pulse in the cycle after the last pixel handshake.
- mem_ce  out  1  connects to the ROM `ce`; combinational.
- mem_addr  out  ADDR_WIDTH  connects to the ROM `addr`; combinational.
- mem_data  in  1  connects to the ROM `out`; valid 1 cycle after mem_ce=1 and held while mem_ce=0.
- out_valid  out  1  pixel available.
- out_ready  in  1  consumer accepts the pixel when out_valid && out_ready.
- out_pixel  out  1  pixel value; driven directly from mem_data.
- out_x  out  XW  column of the current pixel (0..WIDTH-1).
- out_y  out  YW  row of the current pixel (0..HEIGHT-1).
- out_last  out  1  current pixel is (WIDTH-1, HEIGHT-1).

Behaviour:
- Reset (rst=0 at posedge) puts the FSM in IDLE and clears all counters.
  - busy=0, done=0, out_valid=0, out_x=0, out_y=0, out_last=0.
  - mem_ce=0 and mem_addr=0 combinationally while in IDLE.
  - Reset mid-stream aborts immediately. No done pulse is generated, and the next start begins from pixel (0,0).
- FSM states:
  - IDLE: start=1 causes issue counters col=0, row=0 and a move to RUN.
  - RUN: reads are issued. After the read for (WIDTH-1, HEIGHT-1) is issued, the FSM moves to DRAIN.
  - DRAIN: waits for the final pixel handshake. Then it pulses done and returns to IDLE.
- Issue rule: mem_ce = (state==RUN) && (!out_valid || out_ready).
  - A ROM read is issued only when the output slot is empty or is being emptied in the same cycle.
  - Because the ROM holds its output while ce=0, no skid buffer is needed.
- Address: mem_addr = row*WIDTH + col_eff.
  - col_eff = col normally; it is WIDTH-1-col when mirroring is active (see Optional Feature).
  - The address is kept as a running row-base register plus col; no multiplier is used.
- Counter advance on each issue:
  - col increments.
  - On col==WIDTH-1: col returns to 0, row increments, and the row base increases by WIDTH.
- Output registers:
  - out_valid is set the cycle after an issue.
  - out_valid is cleared on a handshake in which no new issue occurs.
  - out_x, out_y and out_last are registered from the issuing col/row in the same cycle as the issue, so they stay aligned with mem_data.
  - out_x reports the logical col, not the mirrored col.
- Throughput and latency:
  - With out_ready held at 1, throughput is 1 pixel/clk.
  - The first out_valid appears 2 cycles after the start cycle: the FSM enters RUN on the 1st edge and the first read completes on the 2nd edge.
- Backpressure: while out_valid && !out_ready, out_pixel, out_x, out_y and out_last are held stable, and no issue occurs.
- start is ignored in RUN and DRAIN.
- done and start in the same cycle: the FSM is still in DRAIN, so the start is ignored.
- WIDTH=1 or HEIGHT=1 must work. The wrap logic must not index out of range.

Optional Feature:
- Macro ASSET_READER_HFLIP_EN.
- When defined:
  - An extra input port `hflip` (1 bit) is added.
  - hflip is sampled on the accepted start and held for the whole stream.
  - When hflip=1, col_eff = WIDTH-1-col, which mirrors the sprite horizontally.
- When undefined: the port is absent and col_eff = col.

Test Plan:
- WIDTH=4, HEIGHT=2, ROM = 8'b1011_0010 (LSB at address 0), out_ready=1, start pulse:
  - mem_addr issues 0..7 on consecutive cycles.
  - out_pixel sequence is 0,1,0,0,1,1,0,1.
  - out_last=1 only at (3,1).
  - done pulses exactly once; busy is high for 9 cycles.
- Same setup, with out_ready toggled 1,0,0,1,... from a random seed: the pixel sequence and coordinates are identical to the previous case, each pixel is accepted exactly once, and held values are stable during stalls.
- Start pulsed again in RUN and in the done cycle: ignored; only one stream and one done pulse are produced.
- rst=0 asserted at the 4th pixel: the next cycle has out_valid=0, busy=0 and mem_ce=0, with no done pulse. A new start restarts from addr 0.
- With ASSET_READER_HFLIP_EN and hflip=1 at start: the address sequence is 3,2,1,0,7,6,5,4, while out_x reports 0,1,2,3.
- WIDTH=1, HEIGHT=3: addresses 0,1,2 are issued, out_x is always 0, out_y is 0,1,2, and done follows the 3rd handshake.
